// File: rtl/req_queue4_if.sv
// Request-queue bus: per-requester push side, selector req/en/gnt loop and the issue register outputs.
interface req_queue4_if;
    logic [3:0]  in_valid;
    logic [31:0] in_tag;
    logic [3:0]  in_ready;
    logic [3:0]  req;
    logic        en;
    logic [3:0]  gnt;
    logic        out_stall;
    logic        out_valid;
    logic [1:0]  out_port;
    logic [7:0]  out_tag;
    logic [15:0] issue_count;

    modport master (
        output in_valid, in_tag, gnt, out_stall,
        input  in_ready, req, en, out_valid, out_port, out_tag, issue_count
    );

    modport slave (
        input  in_valid, in_tag, gnt, out_stall,
        output in_ready, req, en, out_valid, out_port, out_tag, issue_count
    );
endinterface

// File: rtl/req_queue4.sv
// Four 2-deep tag FIFOs feeding an external rotating-priority selector and a single issue register.
// Optional issue counter enabled by defining REQ_QUEUE_ISSUE_COUNT_EN.
module req_queue4 (
    input  logic         clock,
    input  logic         reset,
    req_queue4_if.slave  bus
);
    logic       alive;
    logic [1:0] cnt   [4];
    logic [7:0] slot0 [4];
    logic [7:0] slot1 [4];

    logic [3:0] ready_v;
    logic [3:0] req_v;
    logic [3:0] push;
    logic [3:0] live_gnt;
    logic [3:0] pop;
    logic [1:0] pop_idx;
    logic       any_pop;
    logic       en_v;

    logic       out_valid_q;
    logic [1:0] out_port_q;
    logic [7:0] out_tag_q;

    // alive keeps in_ready low until the first edge after reset release
    always_comb begin
        ready_v = 4'b0000;
        req_v   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ready_v[i] = alive && (cnt[i] != 2'd2);
            req_v[i]   = (cnt[i] != 2'd0);
        end
    end

    assign en_v     = !(out_valid_q && bus.out_stall);
    assign push     = bus.in_valid & ready_v;
    assign live_gnt = bus.gnt & req_v & {4{en_v}};

    always_comb begin
        pop     = 4'b0000;
        pop_idx = 2'd0;
        casez (live_gnt)
            4'b???1: begin pop = 4'b0001; pop_idx = 2'd0; end
            4'b??10: begin pop = 4'b0010; pop_idx = 2'd1; end
            4'b?100: begin pop = 4'b0100; pop_idx = 2'd2; end
            4'b1000: begin pop = 4'b1000; pop_idx = 2'd3; end
            default: begin pop = 4'b0000; pop_idx = 2'd0; end
        endcase
    end

    assign any_pop = |pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alive <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i]   <= 2'd0;
                slot0[i] <= 8'h00;
                slot1[i] <= 8'h00;
            end
        end else begin
            alive <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                case ({push[i], pop[i]})
                    2'b10: begin
                        if (cnt[i] == 2'd0) slot0[i] <= bus.in_tag[8*i +: 8];
                        else                slot1[i] <= bus.in_tag[8*i +: 8];
                        cnt[i] <= cnt[i] + 2'd1;
                    end
                    2'b01: begin
                        slot0[i] <= slot1[i];
                        cnt[i]   <= cnt[i] - 2'd1;
                    end
                    // push+pop only happens at depth 1: new tag becomes the head
                    2'b11: slot0[i] <= bus.in_tag[8*i +: 8];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_port_q  <= 2'd0;
            out_tag_q   <= 8'h00;
        end else if (en_v) begin
            out_valid_q <= any_pop;
            if (any_pop) begin
                out_port_q <= pop_idx;
                out_tag_q  <= slot0[pop_idx];
            end
        end
    end

`ifdef REQ_QUEUE_ISSUE_COUNT_EN
    logic [15:0] issue_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_cnt_q <= 16'h0000;
        end else if (en_v && any_pop && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_q <= issue_cnt_q + 16'd1;
        end
    end

    assign bus.issue_count = issue_cnt_q;
`else
    assign bus.issue_count = 16'h0000;
`endif

    assign bus.in_ready  = ready_v;
    assign bus.req       = req_v;
    assign bus.en        = en_v;
    assign bus.out_valid = out_valid_q;
    assign bus.out_port  = out_port_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: doc/req_queue4.md
REQ_QUEUE4 -- requirements
Module: req_queue4

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; all state cleared while low.
REQ-003 in_valid  input  4  per-requester request valid, bit i = requester i.
REQ-004 in_tag  input  32  per-requester 8-bit tag, requester i at bits [8i+7:8i].
REQ-005 in_ready  output  4  per-requester accept; a transfer occurs when in_valid[i] && in_ready[i].
REQ-006 req  output  4  pending-request vector to the 4-way rotating priority selector.
REQ-007 en  output  1  selector enable; grants are honoured only while en=1.
REQ-008 gnt  input  4  grant vector returned by the selector; one-hot or zero expected.
REQ-009 out_stall  input  1  downstream back-pressure on the issue register.
REQ-010 out_valid  output  1  issued entry valid.
REQ-011 out_port  output  2  index of the requester whose entry is issued.
REQ-012 out_tag  output  8  tag of the issued entry.
REQ-013 issue_count  output  16  total issued entries (see Configuration).

Function
REQ-014 Each requester SHALL own a 2-entry FIFO of tags; per-requester order is preserved.
REQ-015 in_ready[i] SHALL be 1 iff FIFO i holds fewer than 2 entries; it depends on registered state only.
REQ-016 req[i] SHALL be 1 iff FIFO i is non-empty; a push into an empty FIFO becomes visible on req one cycle later (no bypass).
REQ-017 en SHALL equal !(out_valid && out_stall).
REQ-018 When en=1 and gnt[i]=1 with req[i]=1, FIFO i SHALL pop its head in that cycle.
REQ-019 gnt bits with req[i]=0 SHALL be ignored; if more than one valid bit is set, only the lowest index SHALL be popped.
REQ-020 Latency: grant in cycle N SHALL produce out_valid=1, out_port=i, out_tag=popped head at cycle N+1.
REQ-021 While out_valid && out_stall, out_valid/out_port/out_tag SHALL hold and no FIFO SHALL pop.
REQ-022 When not stalled and no honoured grant occurs, out_valid SHALL deassert next cycle; out_port/out_tag keep their last values.
REQ-023 A simultaneous push and pop on a 1-entry FIFO SHALL leave it at 1 entry with the new tag as head.
REQ-024 A full FIFO SHALL not accept (in_ready=0), so push and pop never coincide on a full FIFO.
REQ-025 Pushes on all four ports and one pop SHALL be processed in the same cycle independently.

Reset
REQ-026 While reset=0: all FIFOs empty, in_ready=4'b0000, req=4'b0000, en=1, out_valid=0, out_port=0, out_tag=8'h00, issue_count=0.
REQ-027 From the first clock edge after reset returns to 1, in_ready SHALL be 4'b1111.
REQ-028 Reset asserted mid-operation SHALL discard all queued and issued entries immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro REQ_QUEUE_ISSUE_COUNT_EN defined: issue_count SHALL increment by 1 on each cycle where out_valid rises or a new entry loads the issue register, saturating at 16'hFFFF.
REQ-030 Macro REQ_QUEUE_ISSUE_COUNT_EN undefined: issue_count SHALL be constant 16'h0000 and no counter register SHALL be synthesised.

Verification
REQ-031 Reset release, push tag 8'hA5 on port 2 -> req=4'b0100 next cycle; gnt=4'b0100 -> out_valid=1, out_port=2, out_tag=8'hA5 one cycle later.
REQ-032 Push 8'h11, 8'h22, 8'h33 back-to-back on port 0 with no grants -> in_ready[0]=0 after the second push, third held; grants return 8'h11 then 8'h22, then 8'h33 is accepted.
REQ-033 out_stall=1 with out_valid=1 and gnt=4'b0001 -> en=0, out_tag unchanged, FIFO 0 depth unchanged until stall drops.
REQ-034 gnt=4'b1010 with req=4'b1010 -> only port 1 pops; gnt=4'b0100 with req[2]=0 -> out_valid=0.
REQ-035 Port 3 holds 1 entry (8'h01), grant and push 8'h02 in the same cycle -> out_tag=8'h01 next cycle, req[3] stays 1, next grant yields 8'h02.
REQ-036 reset pulsed low mid-stream with both port-1 entries occupied -> out_valid=0 and req=0 immediately; with REQ_QUEUE_ISSUE_COUNT_EN, issue_count reads 0 afterwards, then 3 after three issues.
